// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, drives the synchronous instruction ROM and holds the IR.
// Optional `MISALIGN_TRAP_EN` adds a sticky misalign_err flag for unaligned redirect targets.
module inst_fetch #(
    parameter int          IMEM_AW  = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic [31:0]        inst,
    output logic               inst_valid,
    output logic [4:0]         opcode,
    output logic [2:0]         func3,
    output logic [6:0]         func7,
    output logic [4:0]         rd,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2
`ifdef MISALIGN_TRAP_EN
    ,
    output logic               misalign_err
`endif
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_ir;
    logic [31:0] w_ir_next;
    logic        r_valid;
    logic        w_valid_next;
    logic [31:0] w_redir_tgt;
    logic        w_take_redirect;

    assign w_redir_tgt = {redirect_pc[31:2], 2'b00};

    // A redirect only counts from a real instruction and never while ctrl is stalling.
    assign w_take_redirect = ((r_state == S_RUN) || (r_state == S_STALL)) &&
                             !stall && redirect && r_valid;

    always_comb begin
        w_state_next = r_state;
        w_nxt        = r_fetch_pc + 32'd4;
        w_pc_next    = r_pc;
        w_ir_next    = r_ir;
        w_valid_next = r_valid;
        case (r_state)
            S_BOOT: begin
                w_nxt        = RESET_PC;
                w_ir_next    = NOP_INST;
                w_valid_next = 1'b0;
                w_state_next = S_RUN;
            end
            S_RUN, S_STALL: begin
                if (stall) begin
                    w_nxt        = r_fetch_pc;
                    w_state_next = S_STALL;
                end else if (w_take_redirect) begin
                    w_nxt        = w_redir_tgt;
                    w_ir_next    = NOP_INST;
                    w_valid_next = 1'b0;
                    w_pc_next    = w_redir_tgt;
                    w_state_next = S_FLUSH;
                end else begin
                    w_ir_next    = imem_rdata;
                    w_pc_next    = r_fetch_pc;
                    w_valid_next = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_FLUSH: begin
                // Re-present the target while stalled so its data is not lost.
                if (stall) begin
                    w_nxt = r_fetch_pc;
                end else begin
                    w_ir_next    = imem_rdata;
                    w_pc_next    = r_fetch_pc;
                    w_valid_next = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            default: begin
                w_nxt        = RESET_PC;
                w_state_next = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_BOOT;
            r_fetch_pc <= RESET_PC;
            r_pc       <= RESET_PC;
            r_ir       <= NOP_INST;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_nxt;
            r_pc       <= w_pc_next;
            r_ir       <= w_ir_next;
            r_valid    <= w_valid_next;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic r_misalign;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_misalign <= 1'b0;
        end else if (w_take_redirect && (redirect_pc[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    assign misalign_err = r_misalign;
`else
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^redirect_pc[1:0];
`endif

    // In reset the state is BOOT, so w_nxt already equals RESET_PC.
    assign imem_addr  = w_nxt[IMEM_AW+1:2];
    assign pc         = r_pc;
    assign pc_plus4   = r_pc + 32'd4;
    assign inst       = r_ir;
    assign inst_valid = r_valid;
    assign opcode     = r_ir[6:2];
    assign func3      = r_ir[14:12];
    assign func7      = r_ir[31:25];
    assign rd         = r_ir[11:7];
    assign rs1        = r_ir[19:15];
    assign rs2        = r_ir[24:20];

endmodule
